// File: rtl/activation_engine_pkg.sv
// -----------------------------------------------------------------------------
// activation_pkg
// Shared types and constants for the activation engine: the FP32 bit-pattern
// type, the activation mode encoding and the FP32 constants used by the lanes.
// No ports (package).
// -----------------------------------------------------------------------------
package activation_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_RELU6 = 2'd3
  } act_mode_e;

  localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
  localparam fp32_t FP32_NEG_ZERO = 32'h8000_0000;
  localparam fp32_t FP32_SIX      = 32'h40C0_0000;

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic fp32_is_nan(input fp32_t val);
    return (val[30:23] == 8'hFF) && (val[22:0] != 23'h0);
  endfunction

endpackage

// File: rtl/activation_engine_if.sv
// -----------------------------------------------------------------------------
// activation_engine_if
// Vector handshake bundle between a producer/consumer (master) and the
// activation engine (slave).
//   in_valid/in_ready  : input vector handshake
//   mode               : activation select, sampled at accept
//   data_in            : VECTOR_LEN FP32 bit patterns
//   out_valid/out_ready: result vector handshake
//   data_out           : VECTOR_LEN FP32 result bit patterns
//   busy               : engine not idle
// -----------------------------------------------------------------------------
interface activation_engine_if #(
  parameter int VECTOR_LEN = 4
);
  import activation_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             mode;
  fp32_t [VECTOR_LEN-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  fp32_t [VECTOR_LEN-1:0] data_out;
  logic                   busy;

  modport master (
    output in_valid, mode, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, mode, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/activation_engine_lane.sv
// -----------------------------------------------------------------------------
// activation_lane
// Combinational per-element activation on an FP32 bit pattern.
//   op_in  : input element
//   mode   : activation select
//   op_out : activated element
// NaN inputs are passed through untouched in every mode.
// -----------------------------------------------------------------------------
module activation_lane
  import activation_pkg::*;
#(
  parameter int LEAK_SHIFT = 3
) (
  input  fp32_t     op_in,
  input  act_mode_e mode,
  output fp32_t     op_out
);

  localparam logic [7:0] SHIFT_E = 8'(LEAK_SHIFT);

  logic        sign_s;
  logic [7:0]  exp_s;
  logic [22:0] man_s;

  assign sign_s = op_in[31];
  assign exp_s  = op_in[30:23];
  assign man_s  = op_in[22:0];

  // Activation select; leaky scales by a power of two via the exponent only.
  always_comb begin
    op_out = op_in;
    if (fp32_is_nan(op_in)) begin
      op_out = op_in;
    end else begin
      case (mode)
        ACT_PASS: op_out = op_in;
        ACT_RELU: begin
          if (sign_s) op_out = FP32_POS_ZERO;
          else        op_out = op_in;
        end
        ACT_LEAKY: begin
          if (!sign_s)                op_out = op_in;
          else if (exp_s == 8'hFF)    op_out = op_in;   // -inf stays -inf
          else if (exp_s > SHIFT_E)   op_out = {1'b1, exp_s - SHIFT_E, man_s};
          else                        op_out = FP32_NEG_ZERO; // would go subnormal: flush
        end
        ACT_RELU6: begin
          // Positive non-NaN patterns order like their values, so an unsigned
          // compare against 6.0 also clamps +inf.
          if (sign_s)                 op_out = FP32_POS_ZERO;
          else if (op_in > FP32_SIX)  op_out = FP32_SIX;
          else                        op_out = op_in;
        end
        default: op_out = op_in;
      endcase
    end
  end

endmodule

// File: rtl/activation_engine.sv
// -----------------------------------------------------------------------------
// activation_engine
// Accepts a VECTOR_LEN-element FP32 vector, applies the selected activation
// LANES elements per cycle and presents the full result until consumed.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : activation_engine_if slave (handshakes, data, mode, busy)
// Result appears NBEATS = VECTOR_LEN/LANES cycles after the accept edge. A new
// vector may be accepted on the same edge the current result is consumed.
// -----------------------------------------------------------------------------
module activation_engine
  import activation_pkg::*;
#(
  parameter int VECTOR_LEN = 4,
  parameter int LANES      = 2,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  activation_engine_if.slave  bus
);

  localparam int NBEATS = VECTOR_LEN / LANES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (VECTOR_LEN % LANES != 0) begin : g_len_check
    $fatal(1, "activation_engine: VECTOR_LEN must be a multiple of LANES");
  end

  logic [1:0]                          state_r;
  logic [1:0]                          state_next_s;
  logic [CNT_W-1:0]                    beat_r;
  act_mode_e                           mode_r;
  fp32_t [NBEATS-1:0][LANES-1:0]       in_vec_r;
  fp32_t [NBEATS-1:0][LANES-1:0]       out_vec_r;
  fp32_t [LANES-1:0]                   lane_out_s;
  logic                                out_valid_r;
  logic                                busy_r;
  logic                                in_ready_s;
  logic                                accept_s;

  // Ready is combinational from out_ready so a consumed result can be
  // replaced on the same edge.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst_n && ((state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready))) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.in_valid && in_ready_s;

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_BUSY;
        else          state_next_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (beat_r == LAST_BEAT) state_next_s = ST_DONE;
        else                     state_next_s = ST_BUSY;
      end
      ST_DONE: begin
        if (!bus.out_ready) state_next_s = ST_DONE;
        else if (accept_s)  state_next_s = ST_BUSY;
        else                state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State plus registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // Capture the operand vector and mode at accept; held for the whole pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vec_r <= '0;
      mode_r   <= ACT_PASS;
    end else if (accept_s) begin
      in_vec_r <= bus.data_in;
      mode_r   <= act_mode_e'(bus.mode);
    end else begin
      in_vec_r <= in_vec_r;
      mode_r   <= mode_r;
    end
  end

  // Beat counter and result write-back, one group of LANES per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_r    <= '0;
      out_vec_r <= '0;
    end else if (state_r == ST_BUSY) begin
      out_vec_r[beat_r] <= lane_out_s;
      if (beat_r == LAST_BEAT) beat_r <= '0;
      else                     beat_r <= beat_r + CNT_W'(1);
    end else begin
      beat_r    <= beat_r;
      out_vec_r <= out_vec_r;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    activation_lane #(
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_lane (
      .op_in  (in_vec_r[beat_r][l]),
      .mode   (mode_r),
      .op_out (lane_out_s[l])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.data_out  = out_vec_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_activation_engine.sv
// -----------------------------------------------------------------------------
// tb_activation_engine
// Self-checking bench for activation_engine (VECTOR_LEN=4, LANES=2,
// LEAK_SHIFT=3): directed vectors, back-to-back handoff, reset mid-pass and
// randomized vectors against a value-level reference model.
// -----------------------------------------------------------------------------
module tb_activation_engine;
  import activation_pkg::*;

  localparam int VL = 4;
  localparam int LN = 2;
  localparam int LS = 3;

  logic clk;
  logic rst_n;

  activation_engine_if #(.VECTOR_LEN(VL)) bus();

  activation_engine #(
    .VECTOR_LEN(VL),
    .LANES     (LN),
    .LEAK_SHIFT(LS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  fp32_t [VL-1:0] exp_vec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: activation rules stated on the sign / exponent / mantissa fields.
  function automatic fp32_t ref_act(input fp32_t x, input logic [1:0] m);
    int  e   = int'(x[30:23]);
    bit  neg = x[31];
    bit  nan = (e == 255) && (x[22:0] != 23'h0);
    if (nan) return x;
    case (m)
      2'd0: return x;
      2'd1: return neg ? 32'h0000_0000 : x;
      2'd2: begin
        if (!neg)       return x;
        if (e == 255)   return x;
        if (e > LS)     return {1'b1, 8'(e - LS), x[22:0]};
        return 32'h8000_0000;
      end
      2'd3: begin
        if (neg)                 return 32'h0000_0000;
        if (x > 32'h40C0_0000)   return 32'h40C0_0000;
        return x;
      end
      default: return x;
    endcase
  endfunction

  function automatic fp32_t pick_operand();
    case ($urandom_range(0, 10))
      0:       return 32'h7F80_0000;
      1:       return 32'hFF80_0000;
      2:       return 32'h0000_0000;
      3:       return 32'h8000_0000;
      4:       return 32'h40C0_0000;
      5:       return 32'h40C0_0001;
      6:       return 32'h8180_0000;
      7:       return 32'h8200_0000;
      8:       return 32'h7FC0_0001;
      default: return fp32_t'($urandom);
    endcase
  endfunction

  // Present a vector, accept it on the next edge, then scramble the inputs.
  task automatic start_vec(input string tag, input logic [1:0] m, input fp32_t [VL-1:0] v);
    for (int i = 0; i < VL; i++) exp_vec[i] = ref_act(v[i], m);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.data_in  = v;
    #1;
    check_value({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.mode     = 2'($urandom);
    bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Wait (bounded) for out_valid; latency counted from the accept edge.
  task automatic wait_result(input string tag);
    int lat = 0;
    check_value({tag, "_busy"}, 128'(bus.busy), 128'(1'b1));
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_value({tag, "_latency"}, 128'(lat), 128'(2));
    check_value({tag, "_data"}, bus.data_out, exp_vec);
  endtask

  task automatic hold_done(input string tag, input int n);
    bus.out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_value({tag, "_hold_valid"}, 128'(bus.out_valid), 128'(1'b1));
      check_value({tag, "_hold_data"}, bus.data_out, exp_vec);
      check_value({tag, "_hold_in_ready"}, 128'(bus.in_ready), 128'(1'b0));
    end
  endtask

  task automatic release_out(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_value({tag, "_rel_valid"}, 128'(bus.out_valid), 128'(1'b0));
    check_value({tag, "_rel_busy"}, 128'(bus.busy), 128'(1'b0));
  endtask

  initial begin
    fp32_t [VL-1:0] v;
    logic  [1:0]    m;
    bit             seen;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode     = 2'd0;
    bus.data_in  = '0;
    bus.out_ready = 1'b0;

    #3;
    check_value("rst_in_ready",  128'(bus.in_ready),  128'(1'b0));
    check_value("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check_value("rst_busy",      128'(bus.busy),      128'(1'b0));
    check_value("rst_data_out",  bus.data_out,        128'h0);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // RELU on {-1, 1, -2, 2}, element 0 in the low word.
    v = {32'h4000_0000, 32'hC000_0000, 32'h3F80_0000, 32'hBF80_0000};
    start_vec("relu", 2'd1, v);
    wait_result("relu");
    check_value("relu_const", bus.data_out,
                {32'h4000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0000});
    release_out("relu");

    // LEAKY: scaled, positive, flushed, -inf.
    v = {32'hFF80_0000, 32'h8080_0000, 32'h4080_0000, 32'hC100_0000};
    start_vec("leaky", 2'd2, v);
    wait_result("leaky");
    check_value("leaky_const", bus.data_out,
                {32'hFF80_0000, 32'h8000_0000, 32'h4080_0000, 32'hBF80_0000});
    release_out("leaky");

    // RELU6: clamp, +inf clamp, in range, -0.
    v = {32'h8000_0000, 32'h40A0_0000, 32'h7F80_0000, 32'h40F0_0000};
    start_vec("relu6", 2'd3, v);
    wait_result("relu6");
    check_value("relu6_const", bus.data_out,
                {32'h0000_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40C0_0000});
    release_out("relu6");

    // NaN passthrough in every mode.
    for (int mi = 0; mi < 4; mi++) begin
      v = {fp32_t'($urandom), fp32_t'($urandom), 32'hFFC0_0000, 32'h7FC0_0000};
      start_vec("nan", 2'(mi), v);
      wait_result("nan");
      check_value("nan_const", 128'(bus.data_out[1:0]), 128'({32'hFFC0_0000, 32'h7FC0_0000}));
      release_out("nan");
    end

    // Stall 5 cycles in DONE, then consume and accept on the same edge.
    v = {32'hC2C8_0000, 32'h4120_0000, 32'h3F00_0000, 32'hBF00_0000};
    start_vec("b2b_a", 2'd3, v);
    wait_result("b2b_a");
    hold_done("b2b_a", 5);
    bus.out_ready = 1'b1;
    v = {32'hC1A0_0000, 32'h4150_0000, 32'h8000_0000, 32'hC080_0000};
    start_vec("b2b_b", 2'd2, v);
    bus.out_ready = 1'b0;
    check_value("b2b_valid_drop", 128'(bus.out_valid), 128'(1'b0));
    wait_result("b2b_b");
    release_out("b2b_b");

    // Reset during beat 1 discards the vector.
    v = {32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
    start_vec("rst_mid", 2'd0, v);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_value("rst_mid_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check_value("rst_mid_data_out",  bus.data_out,        128'h0);
    check_value("rst_mid_busy",      128'(bus.busy),      128'(1'b0));
    check_value("rst_mid_in_ready",  128'(bus.in_ready),  128'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    check_value("rst_mid_quiet", 128'(seen), 128'(1'b0));

    // Randomized vectors, modes and stall lengths.
    for (int it = 0; it < 30; it++) begin
      m = 2'($urandom_range(0, 3));
      for (int i = 0; i < VL; i++) v[i] = pick_operand();
      start_vec("rand", m, v);
      wait_result("rand");
      hold_done("rand", $urandom_range(0, 3));
      release_out("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
